// File: rtl/m_store_buffer.sv
// Lazy store buffer: stores queue here and drain to the DM port on idle cycles, and loads see buffered bytes merged over DM data.
// Zero latency: forwarding and the dm_* outputs are combinational; a non-coalescing store into a full buffer stalls for exactly one cycle.
module m_store_buffer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        M_req_valid,
  input  logic        M_req_we,
  input  logic [31:0] M_adress,
  input  logic [31:0] M_Wdata,
  input  logic [3:0]  M_data_byteen,
  output logic [31:0] M_Rdata,
  output logic        M_stall,
  output logic        dm_WE,
  output logic [31:0] dm_adress,
  output logic [31:0] dm_Wdata,
  output logic [3:0]  dm_byteen,
  input  logic [31:0] dm_Rdata,
  output logic        sb_empty,
  output logic [3:0]  sb_count
);

  localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  byteen;
  } entry_t;

  entry_t        ent_q [DEPTH];
  logic [PW-1:0] head_q, tail_q, newest, idx;
  logic [3:0]    count_q;
  logic          is_store, full, coalesce, push, drain;
  entry_t        merged;
  logic [31:0]   fwd;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign newest   = (tail_q == '0) ? PW'(DEPTH - 1) : tail_q - 1'b1;
  assign is_store = M_req_valid & M_req_we & (|M_data_byteen);
  assign full     = (count_q == DEPTH_C);
  // A drain only ever happens in a store cycle when the store is not coalescing,
  // so a coalescing store never races the head being written out.
  assign coalesce = is_store && (count_q != 4'd0) && (ent_q[newest].waddr == M_adress[31:2]);
  assign push     = is_store & ~coalesce & ~full;
  assign M_stall  = is_store & ~coalesce & full;
  assign drain    = (~M_req_valid & (count_q != 4'd0)) | M_stall;

  assign dm_WE     = drain;
  assign dm_adress = drain ? {ent_q[head_q].waddr, 2'b00} : M_adress;
  assign dm_Wdata  = drain ? ent_q[head_q].data : M_Wdata;
  assign dm_byteen = drain ? ent_q[head_q].byteen : 4'b0000;
  assign sb_empty  = (count_q == 4'd0);
  assign sb_count  = count_q;
  assign M_Rdata   = fwd;

  always_comb begin
    merged        = ent_q[newest];
    merged.byteen = ent_q[newest].byteen | M_data_byteen;
    for (int b = 0; b < 4; b++)
      if (M_data_byteen[b]) merged.data[8*b +: 8] = M_Wdata[8*b +: 8];
  end

  // Walk oldest to newest so the youngest matching byte wins per lane.
  always_comb begin
    fwd = dm_Rdata;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = PW'((int'(head_q) + i) % DEPTH);
      if ((4'(i) < count_q) && (ent_q[idx].waddr == M_adress[31:2]))
        for (int b = 0; b < 4; b++)
          if (ent_q[idx].byteen[b]) fwd[8*b +: 8] = ent_q[idx].data[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      if (push) begin
        ent_q[tail_q] <= '{waddr: M_adress[31:2], data: M_Wdata, byteen: M_data_byteen};
        tail_q        <= ptr_inc(tail_q);
      end
      if (coalesce) ent_q[newest] <= merged;
      if (drain) head_q <= ptr_inc(head_q);
      count_q <= count_q + {3'b000, push} - {3'b000, drain};
    end
  end

endmodule
